ipu_host_ctrl: RTL and testbench
================================

IPU_HOST_CTRL -- requirements
Module: ipu_host_ctrl

Interface
REQ-001 SHALL have parameter HC_DRAIN, default 8: idle cycles after the last instruction load before completion (IPU pipeline depth).
REQ-002 SHALL have parameter HC_FIFO_DEPTH, default 4: result buffer entries (power of 2).
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port hc_rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port hc_start, input, 1: single-cycle request to start a job.
REQ-006 SHALL have port hc_inst_cnt, input, 5: number of instructions in the job, sampled on accepted start.
REQ-007 SHALL have ports hc_row_data (input, 16), hc_row_valid (input, 1), hc_row_ready (output, 1): register-file row stream.
REQ-008 SHALL have ports hc_inst_data (input, 26), hc_inst_valid (input, 1), hc_inst_ready (output, 1): instruction word stream.
REQ-009 SHALL have ports hc_rf_ld_en (output, 1), hc_rf_load (output, 16), hc_rf_ld_adrs (output, 4): register-file load drive to the IPU.
REQ-010 SHALL have ports hc_im_ld_en (output, 1), hc_im_instLoad (output, 26): instruction-memory load drive to the IPU.
REQ-011 SHALL have port hc_ipu_rst, output, 1: IPU reset, active-high.
REQ-012 SHALL have ports hc_ret_valid (input, 1), hc_ret_data (input, 16), hc_ret_adrs (input, 4), hc_ipu_of (input, 1): IPU readback and overflow.
REQ-013 SHALL have ports hc_res_data (output, 16), hc_res_adrs (output, 4), hc_res_valid (output, 1), hc_res_ready (input, 1): result stream to the host.
REQ-014 SHALL have ports hc_busy (output, 1), hc_done (output, 1), hc_of (output, 1), hc_res_ovf (output, 1): status.

Function
REQ-015 SHALL implement FSM states IDLE, RST_IPU, LD_RF, LD_IM, RUN, DONE.
REQ-016 SHALL move IDLE->RST_IPU on hc_start=1 with 1<=hc_inst_cnt<=16, and ignore hc_start in any other case or state.
REQ-017 SHALL, on an accepted start, clear hc_of, hc_res_ovf, row counter and instruction counter.
REQ-018 SHALL assert hc_ipu_rst for exactly the one cycle spent in RST_IPU, then enter LD_RF.
REQ-019 SHALL, in LD_RF, hold hc_row_ready=1; each beat (valid and ready) is presented one cycle later as hc_rf_ld_en=1, hc_rf_load=data, hc_rf_ld_adrs=row counter (0..15, incremented per beat).
REQ-020 SHALL leave LD_RF for LD_IM after beat 16, deasserting hc_row_ready the same cycle that beat is accepted.
REQ-021 SHALL, in LD_IM, hold hc_inst_ready=1; each beat is presented one cycle later as hc_im_ld_en=1, hc_im_instLoad=data.
REQ-022 SHALL enter RUN after beat hc_inst_cnt, then count HC_DRAIN cycles and enter DONE.
REQ-023 SHALL pulse hc_done for the single DONE cycle and return to IDLE.
REQ-024 SHALL hold hc_busy=1 in every state except IDLE.
REQ-025 SHALL drive hc_rf_ld_en and hc_im_ld_en to 0 whenever no beat was accepted in the preceding cycle; stalls (valid=0) neither advance counters nor pulse load enables.
REQ-026 SHALL set hc_of when hc_ipu_of=1 in RUN or DONE; sticky until next accepted start.
REQ-027 SHALL push {hc_ret_adrs, hc_ret_data} into an HC_FIFO_DEPTH FIFO on every hc_ret_valid=1, in any state.
REQ-028 SHALL present the FIFO head on hc_res_data/hc_res_adrs with hc_res_valid=1 when non-empty; a pop occurs on valid and ready.
REQ-029 SHALL, when full with push and pop in the same cycle, accept both; push when full without pop is dropped and sets hc_res_ovf (sticky to next start).
REQ-030 SHALL keep FIFO contents across start and DONE; only reset empties it.

Reset
REQ-031 SHALL, while hc_rst=0, force FSM=IDLE, counters=0, FIFO empty, hc_ipu_rst=1, and all other outputs 0 (data outputs 0).
REQ-032 SHALL abandon any job on mid-operation reset with no hc_done pulse; hc_ipu_rst drops to 0 on the first clock edge after release.

Verification
REQ-033 Full job: start, cnt=3, 16 rows 0x0100+i, 3 instr -> rf_ld_adrs 0..15 with matching data, 3 im_ld_en pulses, hc_done exactly 8 cycles after the last instruction beat, busy low next cycle.
REQ-034 Stalls: row_valid toggled 1,0,1 -> only 2 rf_ld_en pulses, addresses 0,1; no skipped address.
REQ-035 Illegal start: cnt=0 or cnt=17, or start during LD_RF -> FSM unchanged, no hc_ipu_rst pulse.
REQ-036 FIFO: 5 ret_valid pushes with res_ready=0 -> 4 entries held, hc_res_ovf=1, fifth dropped; then full with simultaneous push/pop -> both accepted, order preserved.
REQ-037 Reset mid-LD_IM: hc_rst=0 -> outputs 0, hc_ipu_rst=1, no hc_done; a new start after release runs a full job.
REQ-038 Overflow: hc_ipu_of pulse in RUN -> hc_of=1 through DONE and IDLE; cleared on next accepted start.

Source files
------------

// File: rtl/ipu_host_ctrl.sv
// Host-side sequencer for the IPU: resets it, streams 16 RF rows then N instructions, waits out the pipeline and signals done.
// Latency: each accepted row/instruction beat is driven to the IPU one cycle later; done pulses HC_DRAIN cycles after the last instruction beat.
// Backpressure: row/instr ready asserted only in their load phase; result FIFO pops on valid&ready, pushes beyond capacity are dropped and flagged.
module ipu_host_ctrl #(
    parameter int HC_DRAIN      = 8,
    parameter int HC_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        hc_rst,
    input  logic        hc_start,
    input  logic [4:0]  hc_inst_cnt,
    input  logic [15:0] hc_row_data,
    input  logic        hc_row_valid,
    output logic        hc_row_ready,
    input  logic [25:0] hc_inst_data,
    input  logic        hc_inst_valid,
    output logic        hc_inst_ready,
    output logic        hc_rf_ld_en,
    output logic [15:0] hc_rf_load,
    output logic [3:0]  hc_rf_ld_adrs,
    output logic        hc_im_ld_en,
    output logic [25:0] hc_im_instLoad,
    output logic        hc_ipu_rst,
    input  logic        hc_ret_valid,
    input  logic [15:0] hc_ret_data,
    input  logic [3:0]  hc_ret_adrs,
    input  logic        hc_ipu_of,
    output logic [15:0] hc_res_data,
    output logic [3:0]  hc_res_adrs,
    output logic        hc_res_valid,
    input  logic        hc_res_ready,
    output logic        hc_busy,
    output logic        hc_done,
    output logic        hc_of,
    output logic        hc_res_ovf
);

    typedef enum logic [2:0] {IDLE, RST_IPU, LD_RF, LD_IM, RUN, DONE} state_t;

    localparam int DW = $clog2(HC_DRAIN + 1);
    localparam int AW = $clog2(HC_FIFO_DEPTH);

    state_t        state;
    logic [3:0]    row_cnt;
    logic [4:0]    inst_cnt;
    logic [4:0]    inst_tot;
    logic [DW-1:0] drain_cnt;

    logic start_acc;
    logic row_beat;
    logic inst_beat;

    assign start_acc = (state == IDLE) && hc_start &&
                       (hc_inst_cnt != 5'd0) && (hc_inst_cnt <= 5'd16);
    assign row_beat  = hc_row_valid && hc_row_ready;
    assign inst_beat = hc_inst_valid && hc_inst_ready;

    always_ff @(posedge clk or negedge hc_rst) begin
        if (!hc_rst) begin
            state          <= IDLE;
            row_cnt        <= '0;
            inst_cnt       <= '0;
            inst_tot       <= '0;
            drain_cnt      <= '0;
            hc_row_ready   <= 1'b0;
            hc_inst_ready  <= 1'b0;
            hc_rf_ld_en    <= 1'b0;
            hc_rf_load     <= '0;
            hc_rf_ld_adrs  <= '0;
            hc_im_ld_en    <= 1'b0;
            hc_im_instLoad <= '0;
            hc_ipu_rst     <= 1'b1;
            hc_busy        <= 1'b0;
            hc_done        <= 1'b0;
            hc_of          <= 1'b0;
        end else begin
            hc_rf_ld_en <= row_beat;
            if (row_beat) begin
                hc_rf_load    <= hc_row_data;
                hc_rf_ld_adrs <= row_cnt;
            end
            hc_im_ld_en <= inst_beat;
            if (inst_beat) begin
                hc_im_instLoad <= hc_inst_data;
            end
            hc_ipu_rst <= 1'b0;
            hc_done    <= 1'b0;
            if ((state == RUN || state == DONE) && hc_ipu_of) begin
                hc_of <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_acc) begin
                        state      <= RST_IPU;
                        inst_tot   <= hc_inst_cnt;
                        row_cnt    <= '0;
                        inst_cnt   <= '0;
                        drain_cnt  <= '0;
                        hc_of      <= 1'b0;
                        hc_ipu_rst <= 1'b1;
                        hc_busy    <= 1'b1;
                    end
                end
                RST_IPU: begin
                    state        <= LD_RF;
                    hc_row_ready <= 1'b1;
                end
                LD_RF: begin
                    if (row_beat) begin
                        row_cnt <= row_cnt + 4'd1;
                        if (row_cnt == 4'd15) begin
                            state         <= LD_IM;
                            hc_row_ready  <= 1'b0;
                            hc_inst_ready <= 1'b1;
                        end
                    end
                end
                LD_IM: begin
                    if (inst_beat) begin
                        inst_cnt <= inst_cnt + 5'd1;
                        if (inst_cnt + 5'd1 == inst_tot) begin
                            state         <= RUN;
                            hc_inst_ready <= 1'b0;
                            drain_cnt     <= '0;
                        end
                    end
                end
                RUN: begin
                    // RUN lasts exactly HC_DRAIN cycles so done lands HC_DRAIN edges after the last beat
                    if (drain_cnt == DW'(HC_DRAIN - 1)) begin
                        state   <= DONE;
                        hc_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    hc_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [19:0] fifo_mem [HC_FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;

    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign hc_res_valid = !fifo_empty;
    assign pop          = hc_res_valid && hc_res_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign push         = hc_ret_valid && (!fifo_full || pop);
    assign {hc_res_adrs, hc_res_data} = fifo_empty ? 20'd0 : fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {hc_ret_adrs, hc_ret_data};
        end
    end

    always_ff @(posedge clk or negedge hc_rst) begin
        if (!hc_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            hc_res_ovf <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (start_acc) begin
                hc_res_ovf <= 1'b0;
            end else if (hc_ret_valid && fifo_full && !pop) begin
                hc_res_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ipu_host_ctrl.sv
// Randomized bench for ipu_host_ctrl against a transaction-level model of jobs, status flags and the result FIFO.
module tb_ipu_host_ctrl;

    localparam int HC_DRAIN = 8;
    localparam int DEPTH    = 4;

    logic        clk = 1'b0;
    logic        hc_rst = 1'b1;
    logic        hc_start = 1'b0;
    logic [4:0]  hc_inst_cnt = '0;
    logic [15:0] hc_row_data = '0;
    logic        hc_row_valid = 1'b0;
    logic        hc_row_ready;
    logic [25:0] hc_inst_data = '0;
    logic        hc_inst_valid = 1'b0;
    logic        hc_inst_ready;
    logic        hc_rf_ld_en;
    logic [15:0] hc_rf_load;
    logic [3:0]  hc_rf_ld_adrs;
    logic        hc_im_ld_en;
    logic [25:0] hc_im_instLoad;
    logic        hc_ipu_rst;
    logic        hc_ret_valid = 1'b0;
    logic [15:0] hc_ret_data = '0;
    logic [3:0]  hc_ret_adrs = '0;
    logic        hc_ipu_of = 1'b0;
    logic [15:0] hc_res_data;
    logic [3:0]  hc_res_adrs;
    logic        hc_res_valid;
    logic        hc_res_ready = 1'b0;
    logic        hc_busy;
    logic        hc_done;
    logic        hc_of;
    logic        hc_res_ovf;

    ipu_host_ctrl #(.HC_DRAIN(HC_DRAIN), .HC_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .hc_rst(hc_rst), .hc_start(hc_start), .hc_inst_cnt(hc_inst_cnt),
        .hc_row_data(hc_row_data), .hc_row_valid(hc_row_valid), .hc_row_ready(hc_row_ready),
        .hc_inst_data(hc_inst_data), .hc_inst_valid(hc_inst_valid), .hc_inst_ready(hc_inst_ready),
        .hc_rf_ld_en(hc_rf_ld_en), .hc_rf_load(hc_rf_load), .hc_rf_ld_adrs(hc_rf_ld_adrs),
        .hc_im_ld_en(hc_im_ld_en), .hc_im_instLoad(hc_im_instLoad), .hc_ipu_rst(hc_ipu_rst),
        .hc_ret_valid(hc_ret_valid), .hc_ret_data(hc_ret_data), .hc_ret_adrs(hc_ret_adrs),
        .hc_ipu_of(hc_ipu_of), .hc_res_data(hc_res_data), .hc_res_adrs(hc_res_adrs),
        .hc_res_valid(hc_res_valid), .hc_res_ready(hc_res_ready), .hc_busy(hc_busy),
        .hc_done(hc_done), .hc_of(hc_of), .hc_res_ovf(hc_res_ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_edge = -100;
    int done_cnt = 0;
    int rf_cnt  = 0;
    int im_cnt  = 0;

    // model state
    logic [19:0] rf_q[$];
    logic [25:0] im_q[$];
    logic [19:0] fifo_q[$];
    logic        job_active = 1'b0;
    logic        draining   = 1'b0;
    logic        of_m       = 1'b0;
    logic        ovf_m      = 1'b0;
    logic        rst_exp    = 1'b1;
    logic        accept;
    logic        done_exp;
    logic        pop_m;
    logic [19:0] e_rf;
    logic [25:0] e_im;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!hc_rst) begin
            fifo_q.delete(); rf_q.delete(); im_q.delete();
            ovf_m = 1'b0; of_m = 1'b0; job_active = 1'b0; draining = 1'b0; rst_exp = 1'b1;
        end else begin
            done_exp = draining && (cyc == last_edge + HC_DRAIN);
            chk("busy", hc_busy, job_active);
            chk("ipu_rst", hc_ipu_rst, rst_exp);
            chk("done", hc_done, done_exp);
            chk("of", hc_of, of_m);
            chk("res_ovf", hc_res_ovf, ovf_m);
            chk("res_vld", hc_res_valid, fifo_q.size() != 0);
            if (fifo_q.size() != 0) chk("res_dat", {hc_res_adrs, hc_res_data}, fifo_q[0]);
            if (hc_rf_ld_en) begin
                rf_cnt++;
                if (rf_q.size() == 0) chk("rf_extra", hc_rf_ld_en, 0);
                else begin
                    e_rf = rf_q.pop_front();
                    chk("rf_dat", hc_rf_load, e_rf[15:0]);
                    chk("rf_adr", hc_rf_ld_adrs, e_rf[19:16]);
                end
            end
            if (hc_im_ld_en) begin
                im_cnt++;
                if (im_q.size() == 0) chk("im_extra", hc_im_ld_en, 0);
                else begin
                    e_im = im_q.pop_front();
                    chk("im_dat", hc_im_instLoad, e_im);
                end
            end
            if (hc_done) done_cnt++;
            // model update for the coming edge
            accept = hc_start && !job_active && (hc_inst_cnt >= 5'd1) && (hc_inst_cnt <= 5'd16);
            rst_exp = accept;
            if (hc_ipu_of && draining) of_m = 1'b1;
            pop_m = (fifo_q.size() != 0) && hc_res_ready;
            if (pop_m) void'(fifo_q.pop_front());
            if (hc_ret_valid) begin
                if (fifo_q.size() < DEPTH) fifo_q.push_back({hc_ret_adrs, hc_ret_data});
                else ovf_m = 1'b1;
            end
            if (accept) begin of_m = 1'b0; ovf_m = 1'b0; job_active = 1'b1; end
            if (done_exp) begin job_active = 1'b0; draining = 1'b0; end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int ncyc);
        hc_rst = 1'b0;
        hc_start = 1'b0; hc_row_valid = 1'b0; hc_inst_valid = 1'b0;
        hc_ret_valid = 1'b0; hc_res_ready = 1'b0; hc_ipu_of = 1'b0;
        #1;
        chk("rst_ipu", hc_ipu_rst, 1);
        chk("rst_out_a", {hc_row_ready, hc_inst_ready, hc_rf_ld_en, hc_rf_load, hc_rf_ld_adrs,
                          hc_im_ld_en, hc_busy, hc_done, hc_of, hc_res_ovf}, 0);
        chk("rst_out_b", {hc_im_instLoad, hc_res_data, hc_res_adrs, hc_res_valid}, 0);
        repeat (ncyc) @(posedge clk);
        #1 hc_rst = 1'b1;
    endtask

    task automatic run_job(input int cnt, input int vp, input int abort_at, input bit of_mode, input bit seq);
        int  n, guard, rf0, im0, d0;
        bit  first;
        logic acc;
        rf0 = rf_cnt; im0 = im_cnt; d0 = done_cnt;
        hc_start = 1'b1; hc_inst_cnt = 5'(cnt);
        tick();
        hc_start = 1'b0;
        n = 0; guard = 0;
        hc_row_data = seq ? 16'h0100 : 16'($urandom);
        while (n < 16 && guard < 500) begin
            hc_row_valid = ($urandom_range(99) < vp);
            hc_start     = ($urandom_range(7) == 0);
            hc_inst_cnt  = 5'($urandom_range(1, 16));
            hc_ipu_of    = ($urandom_range(7) == 0);
            @(negedge clk);
            acc = hc_row_valid && hc_row_ready;
            if (acc) rf_q.push_back({4'(n), hc_row_data});
            tick();
            guard++;
            if (acc) begin
                n++;
                hc_row_data = seq ? 16'(16'h0100 + n) : 16'($urandom);
            end
        end
        hc_start = 1'b0; hc_row_valid = 1'b0;
        chk("rows_acc", n, 16);
        @(negedge clk);
        chk("row_rdy_drop", hc_row_ready, 0);
        chk("inst_rdy_up", hc_inst_ready, 1);
        tick();
        n = 0; guard = 0;
        hc_inst_data = 26'($urandom);
        while (n < cnt && guard < 500) begin
            hc_inst_valid = ($urandom_range(99) < vp);
            hc_ipu_of     = ($urandom_range(7) == 0);
            @(negedge clk);
            acc = hc_inst_valid && hc_inst_ready;
            if (acc) begin
                im_q.push_back(hc_inst_data);
                if (n + 1 == cnt) last_edge = cyc + 1;
            end
            tick();
            guard++;
            if (acc) begin n++; hc_inst_data = 26'($urandom); end
            if (n == abort_at) begin
                do_reset(3);
                repeat (HC_DRAIN + 4) tick();
                chk("abort_nodone", done_cnt - d0, 0);
                chk("abort_idle", hc_busy, 0);
                return;
            end
        end
        hc_inst_valid = 1'b0;
        chk("insts_acc", n, cnt);
        draining = 1'b1;
        guard = 0; first = 1'b1;
        while (done_cnt == d0 && guard < 100) begin
            hc_ipu_of = of_mode && (first || $urandom_range(3) == 0);
            first = 1'b0;
            tick();
            guard++;
        end
        hc_ipu_of = 1'b0;
        chk("done_seen", done_cnt - d0, 1);
        chk("rf_pulses", rf_cnt - rf0, 16);
        chk("im_pulses", im_cnt - im0, cnt);
    endtask

    initial begin
        #2 do_reset(3);
        // starts with out-of-range counts are ignored
        hc_start = 1'b1; hc_inst_cnt = 5'd0;  tick();
        hc_inst_cnt = 5'd17; tick();
        hc_inst_cnt = 5'($urandom_range(18, 31)); tick();
        hc_start = 1'b0; tick(); tick();
        chk("ill_busy", hc_busy, 0);
        chk("ill_iprst", hc_ipu_rst, 0);

        // overfill the result FIFO with nobody reading
        for (int i = 0; i < 5; i++) begin
            hc_ret_valid = 1'b1; hc_ret_data = 16'($urandom); hc_ret_adrs = 4'($urandom);
            tick();
        end
        hc_ret_valid = 1'b0;
        @(negedge clk);
        chk("ovf_set", hc_res_ovf, 1);
        chk("fifo_held", hc_res_valid, 1);
        tick();
        hc_ret_valid = 1'b1; hc_res_ready = 1'b1;
        hc_ret_data = 16'($urandom); hc_ret_adrs = 4'($urandom);
        tick();
        hc_ret_valid = 1'b0; hc_res_ready = 1'b0;
        tick();

        // jobs run with the FIFO still holding entries
        run_job(3, 100, -1, 1'b0, 1'b1);
        run_job($urandom_range(1, 16), 60, -1, 1'b1, 1'b0);
        repeat (3) tick();
        chk("of_sticky", hc_of, 1);
        run_job($urandom_range(1, 16), 70, -1, 1'b0, 1'b0);
        chk("of_clr", hc_of, 0);
        run_job(8, 80, 4, 1'b0, 1'b0);
        run_job(16, 50, -1, 1'b0, 1'b0);

        // random result traffic
        for (int i = 0; i < 300; i++) begin
            hc_ret_valid = ($urandom_range(99) < 55);
            hc_ret_data  = 16'($urandom);
            hc_ret_adrs  = 4'($urandom);
            hc_res_ready = ($urandom_range(99) < 45);
            tick();
        end
        hc_ret_valid = 1'b0; hc_res_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        chk("fifo_drained", hc_res_valid, 0);
        hc_res_ready = 1'b0;
        run_job($urandom_range(1, 16), 90, -1, 1'b1, 1'b0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
